mul_exec_unit: RTL and testbench

Multi-cycle execute-stage multiply unit for the 5-stage pipeline: accepts a LEGv8 multiply (MUL, SMULH, UMULH) from the ID/EX register, latches operands, and evaluates them with the existing combinational `mult` block over a fixed number of cycles. It then presents the selected 64-bit half plus destination tag to the EX/MEM register. It drives a stall to the hazard unit while busy and honours pipeline flushes.

---
 rtl/mul_exec_unit.sv | 138 +++++++++++++
 tb/tb_mul_exec_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_exec_unit.sv
// Multi-cycle EX-stage multiply unit: latches a LEGv8 MUL/SMULH/UMULH,
// waits LATENCY cycles on the combinational mult block, then pulses done.

module mult (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        doSigned,
    output logic [63:0] mult_low,
    output logic [63:0] mult_high
);
    logic [127:0] a_ext;
    logic [127:0] b_ext;
    logic [127:0] prod;

    // Sign-extending both operands to 128 bits makes one unsigned multiply
    // produce the correct two's-complement product for the signed case.
    always_comb begin
        a_ext = {{64{a[63] & doSigned}}, a};
        b_ext = {{64{b[63] & doSigned}}, b};
        prod  = a_ext * b_ext;
    end

    assign mult_low  = prod[63:0];
    assign mult_high = prod[127:64];
endmodule

module mul_exec_unit #(
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [63:0] result,
    output logic [4:0]  rd_out
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [63:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;

    logic [63:0] mult_low;
    logic [63:0] mult_high;
    logic [63:0] sel_half;

    mult u_mult (
        .a        (a_q),
        .b        (b_q),
        .doSigned (op_q == 2'b01),
        .mult_low (mult_low),
        .mult_high(mult_high)
    );

    assign sel_half = (op_q == 2'b01 || op_q == 2'b10) ? mult_high : mult_low;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        rd_d     = rd_q;
        result_d = result_q;
        rd_out_d = rd_out_q;

        case (state_q)
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    result_d = sel_half;
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // DONE accepts exactly like IDLE, giving back-to-back issue.
            default: begin
                if (start && !flush) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op;
                    rd_d    = rd_in;
                    cnt_d   = CNT_LOAD;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    assign busy   = (state_q == S_BUSY);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;
endmodule

// File: tb/tb_mul_exec_unit.sv
// Randomized self-checking bench for mul_exec_unit against an arithmetic
// reference model; covers LATENCY=4 and LATENCY=1 builds.

module tb_mul_exec_unit;
    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, flush;
    logic [1:0]  op;
    logic [63:0] A, B;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [63:0] result;
    logic [4:0]  rd_out;

    logic        start1, flush1;
    logic [1:0]  op1;
    logic [63:0] A1, B1;
    logic [4:0]  rd_in1;
    logic        busy1, done1;
    logic [63:0] result1;
    logic [4:0]  rd_out1;

    int checks = 0;
    int errors = 0;
    logic [63:0] last_res;
    logic [4:0]  last_rd;

    always #5 clk = ~clk;

    mul_exec_unit #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .rd_in(rd_in), .flush(flush), .busy(busy), .done(done),
        .result(result), .rd_out(rd_out)
    );

    mul_exec_unit #(.LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op1), .A(A1), .B(B1),
        .rd_in(rd_in1), .flush(flush1), .busy(busy1), .done(done1),
        .result(result1), .rd_out(rd_out1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Signed high half derived from the unsigned product with the usual
    // two's-complement correction terms.
    function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [63:0]  uh, sh;
        p  = {64'd0, a} * {64'd0, b};
        uh = p[127:64];
        sh = uh - (a[63] ? b : 64'd0) - (b[63] ? a : 64'd0);
        case (o)
            2'b01:   return sh;
            2'b10:   return uh;
            default: return p[63:0];
        endcase
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the LATENCY=4 unit and follow it into its DONE cycle.
    task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input bit noise);
        logic [63:0] exp;
        exp = ref_mul(o, a, b);
        op = o; A = a; B = b; rd_in = rd; start = 1'b1; flush = 1'b0;
        step();
        for (int unsigned i = 0; i < LAT; i++) begin
            chk("busy", {63'd0, busy}, 64'd1);
            chk("done_early", {63'd0, done}, 64'd0);
            if (noise) begin
                A = (i == 0) ? 64'd100 : {$urandom, $urandom};
                B = {$urandom, $urandom};
                op = 2'($urandom);
                rd_in = 5'($urandom);
                start = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        chk("done", {63'd0, done}, 64'd1);
        chk("busy_in_done", {63'd0, busy}, 64'd0);
        chk("result", result, exp);
        chk("rd_out", {59'd0, rd_out}, {59'd0, rd});
        last_res = exp;
        last_rd  = rd;
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [63:0] ea, eb;
        logic [1:0]  eo;
        int unsigned k;

        reset = 1'b0; start = 1'b1; flush = 1'b0; op = 2'b00; A = 64'd3; B = 64'd7; rd_in = 5'd9;
        start1 = 1'b0; flush1 = 1'b0; op1 = 2'b00; A1 = '0; B1 = '0; rd_in1 = '0;
        step();
        step();
        expect_idle("reset");
        chk("reset_result", result, 64'd0);
        chk("reset_rd", {59'd0, rd_out}, 64'd0);
        reset = 1'b1; start = 1'b0;
        step();
        expect_idle("post_reset");
        step();
        expect_idle("post_reset2");

        issue(2'b00, 64'd3, 64'd7, 5'd9, 1'b1);
        step();
        expect_idle("after_mul");

        issue(2'b01, '1, 64'd1, 5'd1, 1'b0);
        chk("smulh_m1_1", result, '1);
        step();
        issue(2'b10, '1, 64'd1, 5'd2, 1'b0);
        chk("umulh_m1_1", result, 64'd0);
        step();
        issue(2'b10, '1, '1, 5'd3, 1'b0);
        chk("umulh_m1_m1", result, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        issue(2'b01, '1, '1, 5'd4, 1'b0);
        chk("smulh_m1_m1", result, 64'd0);
        step();
        issue(2'b11, 64'd5, 64'd6, 5'd5, 1'b0);
        chk("op11", result, 64'd30);
        step();

        // Back-to-back: start in the DONE cycle.
        issue(2'b00, 64'd3, 64'd7, 5'd9, 1'b0);
        start = 1'b1; op = 2'b00; A = 64'd2; B = 64'd2; rd_in = 5'd4;
        step();
        start = 1'b0;
        for (int unsigned i = 0; i < LAT; i++) begin
            chk("b2b_busy", {63'd0, busy}, 64'd1);
            chk("b2b_done_early", {63'd0, done}, 64'd0);
            step();
        end
        chk("b2b_done", {63'd0, done}, 64'd1);
        chk("b2b_result", result, 64'd4);
        chk("b2b_rd", {59'd0, rd_out}, 64'd4);
        step();
        expect_idle("b2b_after");

        // Flush in 2nd BUSY cycle; result must keep 21.
        issue(2'b00, 64'd3, 64'd7, 5'd9, 1'b0);
        step();
        op = 2'b00; A = 64'd11; B = 64'd13; rd_in = 5'd7; start = 1'b1;
        step();
        start = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            expect_idle("flush");
            step();
        end
        chk("flush_result", result, 64'd21);
        chk("flush_rd", {59'd0, rd_out}, 64'd9);

        // Flush in DONE: done visible, no accept, back to IDLE.
        issue(2'b00, 64'd8, 64'd8, 5'd8, 1'b0);
        start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        expect_idle("flush_done");

        // start+flush together in IDLE.
        start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        expect_idle("sf_idle");
        step();
        expect_idle("sf_idle2");

        for (int n = 0; n < 25; n++) begin
            ea = pick(); eb = pick(); eo = 2'($urandom);
            issue(eo, ea, eb, 5'($urandom), 1'b1);
            step();
            expect_idle("rand_after");
        end

        // Random-point flushes.
        for (int n = 0; n < 6; n++) begin
            k = $urandom_range(1, LAT);
            op = 2'($urandom); A = pick(); B = pick(); rd_in = 5'($urandom); start = 1'b1;
            step();
            start = 1'b0;
            for (int unsigned i = 1; i < k; i++) step();
            chk("rflush_busy", {63'd0, busy}, 64'd1);
            flush = 1'b1;
            step();
            flush = 1'b0;
            for (int i = 0; i < 6; i++) begin
                expect_idle("rflush");
                step();
            end
            chk("rflush_result", result, last_res);
            chk("rflush_rd", {59'd0, rd_out}, {59'd0, last_rd});
        end

        // Reset in 3rd BUSY cycle.
        op = 2'b00; A = 64'd3; B = 64'd7; rd_in = 5'd9; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("rst_mid_busy_pre", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        expect_idle("rst_mid");
        chk("rst_mid_result", result, 64'd0);
        chk("rst_mid_rd", {59'd0, rd_out}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            expect_idle("rst_mid_after");
        end

        // LATENCY=1 build.
        for (int n = 0; n < 6; n++) begin
            logic [63:0] exp1;
            if (n == 0) begin
                op1 = 2'b00; A1 = 64'd4; B1 = 64'd5;
            end else begin
                op1 = 2'($urandom); A1 = pick(); B1 = pick();
            end
            rd_in1 = 5'($urandom);
            exp1 = ref_mul(op1, A1, B1);
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            chk("l1_busy", {63'd0, busy1}, 64'd1);
            chk("l1_done_early", {63'd0, done1}, 64'd0);
            step();
            chk("l1_done", {63'd0, done1}, 64'd1);
            chk("l1_result", result1, exp1);
            chk("l1_rd", {59'd0, rd_out1}, {59'd0, rd_in1});
            step();
            chk("l1_idle_busy", {63'd0, busy1}, 64'd0);
            chk("l1_idle_done", {63'd0, done1}, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
